// File: rtl/barrel_rotator_pkg.sv
// Shared constants for the barrel rotator: default widths and direction encoding.
package barrel_rotator_pkg;

  // Default data word width in bits.
  localparam int N_DEFAULT = 16;

  // Default width of the rotation-amount field (amounts 0..2^S-1).
  localparam int S_DEFAULT = 3;

  // Direction select encoding on i_select.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage : barrel_rotator_pkg

// File: rtl/rotation_left_shifter.sv
// Logarithmic left rotator: stage j rotates left by 2^j (mod N) when amount bit j is set.
module rotation_left_shifter
  import barrel_rotator_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic [N-1:0] i_num,
  input  logic [S-1:0] i_num_bit_rotation,
  output logic [N-1:0] o_result
);

  // Left rotate by a fixed amount; amt is already reduced below N.
  function automatic logic [N-1:0] rot_l(input logic [N-1:0] x, input int amt);
    logic [N-1:0] y;
    for (int b = 0; b < N; b++) begin
      y[b] = x[(b + N - amt) % N];
    end
    return y;
  endfunction

  // stage[0] is the input word, stage[S] the fully rotated word.
  logic [S:0][N-1:0] stage;

  assign stage[0] = i_num;

  for (genvar j = 0; j < S; j++) begin : g_stage
    // Reducing each stage's weight modulo N makes the total rotation r mod N.
    localparam int AMT = (1 << j) % N;
    assign stage[j+1] = i_num_bit_rotation[j] ? rot_l(stage[j], AMT) : stage[j];
  end

  assign o_result = stage[S];

endmodule : rotation_left_shifter

// File: rtl/rotation_right_shifter.sv
// Logarithmic right rotator: stage j rotates right by 2^j (mod N) when amount bit j is set.
module rotation_right_shifter
  import barrel_rotator_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic [N-1:0] i_num,
  input  logic [S-1:0] i_num_bit_rotation,
  output logic [N-1:0] o_result
);

  // Right rotate by a fixed amount; amt is already reduced below N.
  function automatic logic [N-1:0] rot_r(input logic [N-1:0] x, input int amt);
    logic [N-1:0] y;
    for (int b = 0; b < N; b++) begin
      y[b] = x[(b + amt) % N];
    end
    return y;
  endfunction

  // stage[0] is the input word, stage[S] the fully rotated word.
  logic [S:0][N-1:0] stage;

  assign stage[0] = i_num;

  for (genvar j = 0; j < S; j++) begin : g_stage
    // Reducing each stage's weight modulo N makes the total rotation r mod N.
    localparam int AMT = (1 << j) % N;
    assign stage[j+1] = i_num_bit_rotation[j] ? rot_r(stage[j], AMT) : stage[j];
  end

  assign o_result = stage[S];

endmodule : rotation_right_shifter

// File: rtl/selection_result.sv
// Direction mux: picks the right- or left-rotated word according to i_select.
module selection_result
  import barrel_rotator_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] i_r_num,
  input  logic [N-1:0] i_l_num,
  input  logic         i_select,
  output logic [N-1:0] o_result
);

  // Left word when the select carries the left encoding, otherwise the right word.
  always_comb begin
    o_result = i_r_num;
    if (i_select == DIR_LEFT) begin
      o_result = i_l_num;
    end
  end

endmodule : selection_result

// File: rtl/barrel_rotator.sv
// Registered N-bit barrel rotator: both rotators evaluate every cycle, a mux picks
// the direction, and one register stage captures the result on valid input.
module barrel_rotator
  import barrel_rotator_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int S = S_DEFAULT
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [N-1:0] i_num,
  input  logic [S-1:0] i_num_bit_rotation,
  input  logic         i_select,
  output logic         o_valid,
  output logic [N-1:0] o_result
);

  logic [N-1:0] r_num;
  logic [N-1:0] l_num;
  logic [N-1:0] sel_num;

  logic [N-1:0] result_d, result_q;
  logic         valid_d, valid_q;

  rotation_right_shifter #(.N(N), .S(S)) u_right (
    .i_num              (i_num),
    .i_num_bit_rotation (i_num_bit_rotation),
    .o_result           (r_num)
  );

  rotation_left_shifter #(.N(N), .S(S)) u_left (
    .i_num              (i_num),
    .i_num_bit_rotation (i_num_bit_rotation),
    .o_result           (l_num)
  );

  selection_result #(.N(N)) u_sel (
    .i_r_num  (r_num),
    .i_l_num  (l_num),
    .i_select (i_select),
    .o_result (sel_num)
  );

  // Capture the selected word only on valid input; otherwise hold the last result.
  always_comb begin
    result_d = result_q;
    valid_d  = i_valid;
    if (i_valid) begin
      result_d = sel_num;
    end
  end

  // Output register stage; reset clears result and valid immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign o_result = result_q;
  assign o_valid  = valid_q;

endmodule : barrel_rotator

// File: tb/tb_barrel_rotator.sv
// Self-checking bench for barrel_rotator: a scoreboard queue holds expected words
// pushed at drive time and popped when the registered result appears.
module tb_barrel_rotator;

  localparam int N = 16;
  localparam int S = 3;

  logic         clk;
  logic         rst_n;
  logic         i_valid;
  logic [N-1:0] i_num;
  logic [S-1:0] i_rot;
  logic         i_select;
  logic         o_valid;
  logic [N-1:0] o_result;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] exp_q[$];

  barrel_rotator #(.N(N), .S(S)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_valid            (i_valid),
    .i_num              (i_num),
    .i_num_bit_rotation (i_rot),
    .i_select           (i_select),
    .o_valid            (o_valid),
    .o_result           (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rotation straight from the index definition.
  function automatic logic [N-1:0] ref_rot(input logic [N-1:0] x, input int r, input logic left);
    logic [N-1:0] y;
    int rr;
    rr = r % N;
    for (int k = 0; k < N; k++) begin
      if (left) y[k] = x[(k - rr + N) % N];
      else      y[k] = x[(k + rr) % N];
    end
    return y;
  endfunction

  // Drive one cycle of inputs, record the expectation, return 1 time unit after the edge.
  task automatic send(input logic v, input logic [N-1:0] num, input logic [S-1:0] r, input logic sel);
    @(negedge clk);
    i_valid  = v;
    i_num    = num;
    i_rot    = r;
    i_select = sel;
    if (v) exp_q.push_back(ref_rot(num, int'(r), sel));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_valid  = 1'b1;
      i_num    = N'($urandom);
      i_rot    = S'($urandom);
      i_select = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if (o_result !== 16'h0000) begin
        errors++; $display("FAIL reset_result got %h want 0000", o_result);
      end
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid got %b want 0", o_valid);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_basic();
    logic [N-1:0] exp;
    send(1'b1, 16'h0006, 3'd1, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (o_result !== 16'h0003 || exp !== 16'h0003) begin
      errors++; $display("FAIL basic_right got %h want 0003", o_result);
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++; $display("FAIL basic_right_valid got %b want 1", o_valid);
    end
    send(1'b1, 16'h0006, 3'd1, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (o_result !== 16'h000C || exp !== 16'h000C) begin
      errors++; $display("FAIL basic_left got %h want 000c", o_result);
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] nums[4]   = '{16'h8001, 16'h8001, 16'h0001, 16'h0001};
    logic [S-1:0] rots[4]   = '{3'd1, 3'd1, 3'd7, 3'd7};
    logic         sels[4]   = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] wants[4]  = '{16'hC000, 16'h0003, 16'h0080, 16'h0200};
    logic [N-1:0] exp;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, nums[i], rots[i], sels[i]);
      exp = exp_q.pop_front();
      checks++;
      if (o_result !== wants[i] || exp !== wants[i]) begin
        errors++; $display("FAIL wrap_%0d got %h want %h", i, o_result, wants[i]);
      end
    end
  endtask

  task automatic test_identity_hold();
    logic [N-1:0] exp;
    for (int d = 0; d < 2; d++) begin
      send(1'b1, 16'hA5C3, 3'd0, 1'(d));
      exp = exp_q.pop_front();
      checks++;
      if (o_result !== 16'hA5C3 || exp !== 16'hA5C3) begin
        errors++; $display("FAIL identity_dir%0d got %h want a5c3", d, o_result);
      end
    end
    for (int i = 0; i < 3; i++) begin
      send(1'b0, N'($urandom), S'($urandom), 1'($urandom));
      checks++;
      if (o_result !== 16'hA5C3) begin
        errors++; $display("FAIL hold_result got %h want a5c3", o_result);
      end
      checks++;
      if (o_valid !== 1'b0) begin
        errors++; $display("FAIL hold_valid got %b want 0", o_valid);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [N-1:0] exp;
    logic [N-1:0] orig;
    logic [N-1:0] mid;
    for (int r = 0; r < (1 << S); r++) begin
      for (int d = 0; d < 2; d++) begin
        send(1'b1, N'($urandom), S'(r), 1'(d));
        exp = exp_q.pop_front();
        checks++;
        if (o_result !== exp) begin
          errors++; $display("FAIL exh_r%0d_d%0d got %h want %h", r, d, o_result, exp);
        end
      end
      // Left by r then right by r must restore the original word.
      orig = N'($urandom);
      send(1'b1, orig, S'(r), 1'b1);
      mid = o_result;
      void'(exp_q.pop_front());
      send(1'b1, mid, S'(r), 1'b0);
      void'(exp_q.pop_front());
      checks++;
      if (o_result !== orig) begin
        errors++; $display("FAIL roundtrip_r%0d got %h want %h", r, o_result, orig);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    for (int i = 0; i < 12; i++) begin
      logic v;
      v = (i % 3) != 2;
      send(v, N'($urandom), S'($urandom), 1'($urandom));
      checks++;
      if (o_valid !== v) begin
        errors++; $display("FAIL b2b_valid_%0d got %b want %b", i, o_valid, v);
      end
      if (v) begin
        exp = exp_q.pop_front();
        checks++;
        if (o_result !== exp) begin
          errors++; $display("FAIL b2b_result_%0d got %h want %h", i, o_result, exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [N-1:0] exp;
    send(1'b1, 16'h1234, 3'd2, 1'b1);
    exp = exp_q.pop_front();
    checks++;
    if (o_result !== 16'h48D0 || exp !== 16'h48D0) begin
      errors++; $display("FAIL pre_async got %h want 48d0", o_result);
    end
    // Keep a valid input pending, then pull reset between edges.
    i_valid = 1'b1;
    i_num   = 16'hFFFF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_result !== 16'h0000) begin
      errors++; $display("FAIL async_result got %h want 0000", o_result);
    end
    checks++;
    if (o_valid !== 1'b0) begin
      errors++; $display("FAIL async_valid got %b want 0", o_valid);
    end
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b1;
    exp_q.delete();
    send(1'b0, 16'h0000, 3'd0, 1'b0);
    checks++;
    if (o_valid !== 1'b0 || o_result !== 16'h0000) begin
      errors++; $display("FAIL post_release_idle got %b/%h want 0/0000", o_valid, o_result);
    end
    send(1'b1, 16'h00F0, 3'd4, 1'b0);
    exp = exp_q.pop_front();
    checks++;
    if (o_valid !== 1'b1 || o_result !== exp) begin
      errors++; $display("FAIL post_release got %b/%h want 1/%h", o_valid, o_result, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    i_valid  = 1'b0;
    i_num    = '0;
    i_rot    = '0;
    i_select = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_identity_hold();
    test_exhaustive();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_barrel_rotator
